// File: rtl/ewb_queue_if.sv
// ----------------------------------------------------------------------------
// ewb_queue_if
//   Line-granular memory request/response bundle. It is used on both sides of
//   the eviction write buffer: upstream (cache side) and downstream (pmem side).
//
//   read     master->slave  read request, held until resp
//   write    master->slave  write request, held until resp
//   address  master->slave  line address
//   wdata    master->slave  write line data
//   rdata    slave->master  read line data, valid with resp
//   resp     slave->master  one-cycle completion of the current request
// ----------------------------------------------------------------------------
interface ewb_queue_if #(
   parameter int ADDR_W = 32,
   parameter int LINE_W = 256
);
   logic              read;
   logic              write;
   logic [ADDR_W-1:0] address;
   logic [LINE_W-1:0] wdata;
   logic [LINE_W-1:0] rdata;
   logic              resp;

   modport master (output read, write, address, wdata, input rdata, resp);
   modport slave  (input read, write, address, wdata, output rdata, resp);
endinterface

// File: rtl/ewb_queue.sv
// ----------------------------------------------------------------------------
// ewb_queue
//   Multi-entry eviction write buffer between the cache writeback path and
//   physical memory. Evicted lines are queued in FIFO order. Writes to a line
//   that is already buffered are merged into that entry. Reads that hit are
//   answered from the buffer. Entries drain to pmem once occupancy reaches
//   DRAIN_THRESH, when upstream is idle, or while flush is held high.
//
//   clk, rst_n   clock and synchronous active-low reset
//   mem          upstream slave port (cache side)
//   pmem         downstream master port (physical memory side)
//   flush        level; while high, drain every entry
//   flush_done   flush && buffer empty && no pmem transaction in flight
//   full, count  occupancy status
// ----------------------------------------------------------------------------
module ewb_queue #(
   parameter  int DEPTH        = 4,
   parameter  int LINE_W       = 256,
   parameter  int ADDR_W       = 32,
   parameter  int DRAIN_THRESH = 2,
   localparam int PTR_W        = $clog2(DEPTH),
   localparam int CNT_W        = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   ewb_queue_if.slave       mem,
   ewb_queue_if.master      pmem,
   input  logic             flush,
   output logic             flush_done,
   output logic             full,
   output logic [CNT_W-1:0] count
);

   typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_FILL} state_e;

   state_e            state_q, state_d;
   logic [DEPTH-1:0]  valid_q, valid_d;
   logic [ADDR_W-1:0] addr_q [DEPTH];
   logic [ADDR_W-1:0] addr_d [DEPTH];
   logic [LINE_W-1:0] data_q [DEPTH];
   logic [LINE_W-1:0] data_d [DEPTH];
   logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
   logic [CNT_W-1:0]  count_q, count_d;

   logic              hit;
   logic [PTR_W-1:0]  hit_idx, lookup_idx;
   logic              wr_req, rd_req, draining, pop, coalesce, alloc, over_thresh;

   assign full        = (count_q == CNT_W'(DEPTH));
   assign count       = count_q;
   assign over_thresh = (count_q >= CNT_W'(DRAIN_THRESH));
   assign flush_done  = flush && (count_q == '0) && (state_q == S_IDLE);

   // Scan oldest to youngest so the youngest match wins. Two entries share an
   // address only when a write to the head arrived while the head was being
   // drained; the younger copy holds the current data.
   always_comb begin
      // NOTE: every combinational output gets a default before any branch, so
      // no path can leave it unassigned and infer a latch.
      hit        = 1'b0;
      hit_idx    = head_q;
      lookup_idx = head_q;
      for (int i = 0; i < DEPTH; i++) begin
         lookup_idx = head_q + PTR_W'(i);
         if (valid_q[lookup_idx] && (addr_q[lookup_idx] == mem.address)) begin
            hit     = 1'b1;
            hit_idx = lookup_idx;
         end
      end
   end

   always_comb begin
      wr_req   = mem.write;
      rd_req   = mem.read && !mem.write;   // write wins if both are raised
      draining = (state_q == S_DRAIN);
      pop      = draining && pmem.resp;
      // The head under drain is frozen: its data is already on the pmem bus.
      coalesce = wr_req && hit && !(draining && (hit_idx == head_q));
      // When full, the slot freed by this cycle's pop can be reused at once.
      alloc    = wr_req && !coalesce && (!full || pop);

      valid_d = valid_q;
      addr_d  = addr_q;
      data_d  = data_q;
      head_d  = head_q;
      tail_d  = tail_q;
      state_d = state_q;

      // The pop clears first, so an allocate into the same slot survives.
      if (pop) begin
         valid_d[head_q] = 1'b0;
         head_d          = head_q + PTR_W'(1);
      end
      if (alloc) begin
         valid_d[tail_q] = 1'b1;
         addr_d[tail_q]  = mem.address;
         data_d[tail_q]  = mem.wdata;
         tail_d          = tail_q + PTR_W'(1);
      end
      if (coalesce) begin
         data_d[hit_idx] = mem.wdata;
      end
      count_d = count_q + CNT_W'(alloc) - CNT_W'(pop);

      unique case (state_q)
         S_IDLE: begin
            if (rd_req && !hit && !over_thresh) begin
               state_d = S_FILL;
            end else if ((count_q != '0) &&
                         (over_thresh || flush || (!mem.read && !mem.write))) begin
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: if (pmem.resp) state_d = S_IDLE;
         S_FILL:  if (pmem.resp) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      mem.resp = (wr_req && (coalesce || alloc)) || (rd_req && hit) ||
                 ((state_q == S_FILL) && pmem.resp);
      mem.rdata = '0;
      if (rd_req && hit) begin
         mem.rdata = data_q[hit_idx];
      end else if ((state_q == S_FILL) && pmem.resp) begin
         mem.rdata = pmem.rdata;
      end

      // Drive the pmem bus only while a transaction is open. The buffer
      // contents are never reset, so the idle bus stays at a defined zero.
      pmem.write   = draining;
      pmem.read    = (state_q == S_FILL);
      pmem.address = '0;
      pmem.wdata   = '0;
      if (draining) begin
         pmem.address = addr_q[head_q];
         pmem.wdata   = data_q[head_q];
      end else if (state_q == S_FILL) begin
         pmem.address = mem.address;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // flop samples pre-edge values and the result is independent of order.
      if (!rst_n) begin
         state_q <= S_IDLE;
         valid_q <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         valid_q <= valid_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // NOTE: the line storage has no reset. The valid bits alone decide whether
   // an entry exists, so clearing wide data arrays would add reset fan-out for
   // no benefit.
   always_ff @(posedge clk) begin
      addr_q <= addr_d;
      data_q <= data_d;
   end

endmodule

// File: tb/tb_ewb_queue.sv
// ----------------------------------------------------------------------------
// tb_ewb_queue
//   Self-checking bench for ewb_queue. The reference model treats the buffer
//   as a queue of pending line writes in front of a memory:
//     - golden[]  holds the latest data written to each line, so any read
//       must return golden[addr];
//     - pend_q    holds the writes that have not yet reached pmem, oldest
//       first, with merging of same-address writes unless the oldest one is
//       already on the pmem bus.
//   The stimulus pushes the expected upstream responses into exp_q. The
//   monitor pops and compares them whenever mem_resp is seen, and it checks
//   every completed pmem write against the head of pend_q.
// ----------------------------------------------------------------------------
module tb_ewb_queue;
   localparam int DEPTH  = 4;
   localparam int LINE_W = 64;
   localparam int ADDR_W = 32;
   localparam int THRESH = 4;

   typedef struct {
      bit          wr;
      logic [31:0] a;
      logic [63:0] d;
   } req_t;

   typedef struct {
      logic [31:0] a;
      logic [63:0] d;
   } line_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       flush = 1'b0;
   logic       flush_done, full;
   logic [2:0] count;

   always #5 clk = ~clk;

   ewb_queue_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) up ();
   ewb_queue_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) pm ();

   ewb_queue #(
      .DEPTH(DEPTH), .LINE_W(LINE_W), .ADDR_W(ADDR_W), .DRAIN_THRESH(THRESH)
   ) dut (
      .clk(clk), .rst_n(rst_n), .mem(up), .pmem(pm), .flush(flush),
      .flush_done(flush_done), .full(full), .count(count)
   );

   int          n_checks = 0;
   int          n_pass = 0;
   int          cyc = 0;
   int          pops = 0;
   int          last_pop_cyc = -1;
   int          wr_resp_cyc = -1;
   int          first_done_cyc = -1;
   logic [31:0] last_fill_addr = '0;
   bit          pm_hold = 1'b0;
   int          pm_wait = 0;

   req_t        exp_q[$];
   line_t       pend_q[$];
   line_t       pm_log[$];
   logic [63:0] golden[logic [31:0]];
   logic [63:0] pm_mem[logic [31:0]];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
   endtask

   // Contents of a line that has never been written.
   function automatic logic [63:0] init_line(input logic [31:0] a);
      return {~a, a};
   endfunction

   function automatic logic [63:0] golden_rd(input logic [31:0] a);
      return golden.exists(a) ? golden[a] : init_line(a);
   endfunction

   function automatic logic [63:0] pm_rd(input logic [31:0] a);
      return pm_mem.exists(a) ? pm_mem[a] : init_line(a);
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Physical memory responder: random 0..3 wait cycles; it can be held off.
   initial begin
      pm.resp  = 1'b0;
      pm.rdata = '0;
      forever begin
         @(posedge clk);
         #1;
         pm.resp = 1'b0;
         if (rst_n && (pm.read || pm.write) && !pm_hold) begin
            if (pm_wait == 0) begin
               pm.resp = 1'b1;
               if (pm.write) pm_mem[pm.address] = pm.wdata;
               else          pm.rdata = pm_rd(pm.address);
               pm_wait = $urandom_range(0, 3);
            end else begin
               pm_wait--;
            end
         end
      end
   end

   // Monitor and scoreboard.
   always @(negedge clk) begin : monitor
      req_t  e;
      line_t f;
      int    hit;
      if (rst_n) begin
         check("count", 64'(count), 64'(pend_q.size()));
         check("full", 64'(full), 64'(pend_q.size() == DEPTH));
         check("flush_done", 64'(flush_done),
               64'(flush && pend_q.size() == 0 && !pm.read && !pm.write));
         if (flush_done && first_done_cyc < 0) first_done_cyc = cyc;

         if (up.resp) begin
            if (exp_q.size() == 0) begin
               check("spurious_mem_resp", 64'(up.resp), 64'(0));
            end else begin
               e = exp_q.pop_front();
               check("resp_kind", 64'(up.write), 64'(e.wr));
               if (e.wr) begin
                  wr_resp_cyc = cyc;
                  hit = -1;
                  for (int i = 0; i < pend_q.size(); i++)
                     if (pend_q[i].a == e.a) hit = i;
                  // The oldest entry is frozen while its pmem write is open.
                  if (hit >= 0 && !(hit == 0 && pm.write)) begin
                     f = pend_q[hit];
                     f.d = e.d;
                     pend_q[hit] = f;
                  end else begin
                     f.a = e.a;
                     f.d = e.d;
                     pend_q.push_back(f);
                  end
               end else begin
                  check("mem_rdata", up.rdata, e.d);
               end
            end
         end

         if (pm.write && pm.resp) begin
            if (pend_q.size() == 0) begin
               check("spurious_pmem_write", 64'(pm.write), 64'(0));
            end else begin
               f = pend_q.pop_front();
               check("pmem_waddr", 64'(pm.address), 64'(f.a));
               check("pmem_wdata", pm.wdata, f.d);
               f.a = pm.address;
               f.d = pm.wdata;
               pm_log.push_back(f);
               pops++;
               last_pop_cyc = cyc;
            end
         end
         if (pm.read && pm.resp) last_fill_addr = pm.address;
      end
   end

   // Issue one upstream request from posedge+1 and hold it until mem_resp.
   task automatic issue(input bit wr, input logic [31:0] a, input logic [63:0] d,
                        output int lat);
      req_t e;
      e.wr = wr;
      e.a  = a;
      if (wr) begin
         e.d = d;
         golden[a] = d;
      end else begin
         e.d = golden_rd(a);
      end
      exp_q.push_back(e);
      up.write   = wr;
      up.read    = !wr;
      up.address = a;
      up.wdata   = wr ? d : '0;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!up.resp && lat < 300);
      if (!up.resp) begin
         check("req_timeout", 64'(up.resp), 64'(1));
         exp_q.delete();
      end
      @(posedge clk);
      #1;
      up.write = 1'b0;
      up.read  = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(count == 0 && !pm.read && !pm.write) && n < 500);
      check("drain_to_empty", 64'(count), 64'(0));
      @(posedge clk);
      #1;
   endtask

   task automatic wait_drain(input logic [31:0] a);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!pm.write && n < 50);
      check("drain_start", 64'(pm.write), 64'(1));
      check("drain_addr", 64'(pm.address), 64'(a));
      @(posedge clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int          lat, lat5, base;
      logic [63:0] d_a, d_b;
      up.read = 1'b0;
      up.write = 1'b0;
      up.address = '0;
      up.wdata = '0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Reset state.
      @(negedge clk);
      check("rst_mem_resp", 64'(up.resp), 64'(0));
      check("rst_mem_rdata", up.rdata, 64'(0));
      check("rst_pmem_read", 64'(pm.read), 64'(0));
      check("rst_pmem_write", 64'(pm.write), 64'(0));
      check("rst_pmem_addr", 64'(pm.address), 64'(0));
      check("rst_pmem_wdata", pm.wdata, 64'(0));
      check("rst_count", 64'(count), 64'(0));
      check("rst_full", 64'(full), 64'(0));
      check("rst_flush_done", 64'(flush_done), 64'(0));
      @(posedge clk);
      #1;

      // Fill to DEPTH with pmem held off; a fifth write must wait.
      pm_hold = 1'b1;
      for (int i = 0; i < 4; i++) begin
         issue(1'b1, 32'h100 * (i + 1), {$urandom, $urandom}, lat);
         check("fill_latency", 64'(lat), 64'(1));
      end
      @(negedge clk);
      check("fill_count", 64'(count), 64'(4));
      check("fill_full", 64'(full), 64'(1));
      @(negedge clk);
      check("fill_drain_write", 64'(pm.write), 64'(1));
      check("fill_drain_addr", 64'(pm.address), 64'(32'h100));
      @(posedge clk);
      #1;
      fork
         issue(1'b1, 32'h500, {$urandom, $urandom}, lat5);
         begin
            repeat (5) @(posedge clk);
            #1;
            pm_wait = 0;
            pm_hold = 1'b0;
         end
      join
      check("fifth_held_off", 64'(lat5 > 5), 64'(1));
      check("fifth_with_pop", 64'(wr_resp_cyc), 64'(last_pop_cyc));
      wait_idle();

      // Coalesce: A then B to the same line; one pmem write carrying B.
      base = pops;
      d_a = {$urandom, $urandom};
      d_b = {$urandom, $urandom};
      issue(1'b1, 32'h100, d_a, lat);
      issue(1'b1, 32'h100, d_b, lat);
      @(negedge clk);
      check("coalesce_count", 64'(count), 64'(1));
      @(posedge clk);
      #1;
      wait_idle();
      check("coalesce_pops", 64'(pops - base), 64'(1));
      check("coalesce_data", pm_log[pm_log.size()-1].d, d_b);

      // Read hit on a buffered line, then a read miss that goes to pmem.
      issue(1'b1, 32'h200, {$urandom, $urandom}, lat);
      issue(1'b0, 32'h200, '0, lat);
      check("hit_latency", 64'(lat), 64'(1));
      issue(1'b0, 32'h900, '0, lat);
      check("miss_went_to_pmem", 64'(lat > 1), 64'(1));
      check("miss_addr", 64'(last_fill_addr), 64'(32'h900));
      wait_idle();

      // A write to the head under drain must land after the older data.
      pm_hold = 1'b1;
      d_a = {$urandom, $urandom};
      d_b = {$urandom, $urandom};
      issue(1'b1, 32'h300, d_a, lat);
      wait_drain(32'h300);
      issue(1'b1, 32'h300, d_b, lat);
      check("hazard_latency", 64'(lat), 64'(1));
      @(negedge clk);
      check("hazard_count", 64'(count), 64'(2));
      @(posedge clk);
      #1;
      pm_hold = 1'b0;
      wait_idle();
      check("hazard_old_first", pm_log[pm_log.size()-2].d, d_a);
      check("hazard_new_last", pm_log[pm_log.size()-1].d, d_b);

      // Flush of three entries; flush_done only after the third pmem_resp.
      base = pops;
      issue(1'b1, 32'hA00, {$urandom, $urandom}, lat);
      issue(1'b1, 32'hB00, {$urandom, $urandom}, lat);
      issue(1'b1, 32'hC00, {$urandom, $urandom}, lat);
      first_done_cyc = -1;
      flush = 1'b1;
      wait_idle();
      check("flush_pops", 64'(pops - base), 64'(3));
      check("flush_done_timing", 64'(first_done_cyc), 64'(last_pop_cyc + 1));
      flush = 1'b0;

      // Randomized traffic over a small address set for frequent hits.
      for (int n = 0; n < 300; n++) begin
         flush = ($urandom_range(0, 9) == 0);
         issue($urandom_range(0, 9) < 6, 32'h1000 + 32'h40 * $urandom_range(0, 5),
               {$urandom, $urandom}, lat);
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
      end
      flush = 1'b0;
      wait_idle();

      // Reset mid-drain discards buffered lines.
      pm_hold = 1'b1;
      issue(1'b1, 32'h700, {$urandom, $urandom}, lat);
      issue(1'b1, 32'h740, {$urandom, $urandom}, lat);
      wait_drain(32'h700);
      rst_n = 1'b0;
      pend_q.delete();
      golden.delete();
      foreach (pm_mem[k]) golden[k] = pm_mem[k];
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_mid_pmem_write", 64'(pm.write), 64'(0));
      check("rst_mid_count", 64'(count), 64'(0));
      check("rst_mid_full", 64'(full), 64'(0));
      check("rst_mid_mem_resp", 64'(up.resp), 64'(0));
      @(posedge clk);
      #1;
      pm_hold = 1'b0;
      issue(1'b0, 32'h700, '0, lat);
      check("rst_discard_miss", 64'(lat > 1), 64'(1));
      wait_idle();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
